serial_compare_controller: RTL and testbench
============================================

// Module: serial_compare_controller
// PURPOSE
//  Multi-cycle magnitude comparator: one two-bit compare slice, time-shared MSB-pair first.
//  Controller latches operands, feeds one pair per cycle, chains eq/lt, stops on first unequal pair.
//  Area-saving alternative to the S/2-slice combinational comparator; start/done handshake to a host FSM.
// PARAMETERS
//  S  8  operand width in bits; even, >= 2; processed as S/2 two-bit pairs
// PORTS
//  clk    in   1  single clock, rising edge
//  rst    in   1  synchronous, active-high reset
//  start  in   1  request; accepted only in IDLE
//  A      in   S  operand A, sampled on accepted start only
//  B      in   S  operand B, sampled on accepted start only
//  busy   out  1  high in RUN
//  done   out  1  one-cycle pulse, result valid
//  EQ     out  1  registered result A==B
//  LT     out  1  registered result A<B (unsigned); EQ=0,LT=0 means A>B
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, busy=0, done=0, EQ=0, LT=0, shift regs/counter=0.
//  rst overrides everything incl. mid-RUN; in-flight compare discarded, no done pulse.
//  States: IDLE -> RUN on start; RUN -> DONE on early exit or last pair; DONE -> IDLE unconditionally.
//  IDLE: start=1 -> load sa<=A, sb<=B, eq_acc<=1, lt_acc<=0, cnt<=S/2-1; go RUN.
//  RUN, each cycle: slice inputs A=sa[S-1:S-2], B=sb[S-1:S-2], eq=eq_acc, lt=lt_acc.
//   eq_acc/lt_acc <= slice EQ/LT; sa,sb <= shift left by 2; cnt <= cnt-1.
//   exit when slice EQ==0 (first differing pair decides) or cnt==0; EQ/LT <= slice outputs on exit edge.
//  DONE: done=1 exactly one cycle, busy=0; start ignored here (back-to-back start costs one IDLE cycle).
//  EQ/LT: change only on RUN exit edge; hold until next completed compare; previous value stays visible during RUN.
//  start while RUN or DONE: ignored, A/B not sampled, no queueing.
//  Latency: k = 1-based index (from MSB) of first differing pair, k=S/2 if A==B.
//   start accepted at edge 0 -> RUN for k cycles -> done high in cycle k+1.
//  cnt width = max(1,$clog2(S/2)); S=2 gives exactly one RUN cycle.
//  No combinational path from inputs to outputs; all outputs registered or state-decoded.
// STRUCTURE
//  Package cmp_ctrl_pkg: typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} cmp_state_t;
//   function cnt_width(int s) returning max(1,$clog2(s/2)).
//  One sub-module: the existing TwoBitCompareSlice, instantiated once, purely combinational.
//  Top: state register, two S-bit shift regs, eq/lt accumulators, down-counter, result regs.
// TESTING (S=8 unless noted; cycle 0 = edge where start is accepted)
//  1. A=8'hA5, B=8'hA5 -> busy cycles 1..4, done cycle 5, EQ=1 LT=0.
//  2. A=8'h3F, B=8'h40 (MSB pair 00<01) -> busy cycle 1 only, done cycle 2, EQ=0 LT=1.
//  3. A=8'hC4, B=8'hC1 (pairs 11=11,00=00,01>00) -> busy 1..3, done cycle 4, EQ=0 LT=0.
//  4. Start A=8'h10,B=8'h20; pulse start with A=B=8'hFF in cycle 1 and in DONE -> ignored; result EQ=0 LT=1.
//  5. rst=1 in cycle 2 of A=B=8'h77 compare -> next cycle busy=0 done=0 EQ=0 LT=0; no done pulse; fresh start completes normally.
//  6. S=4 exhaustive 256 (A,B) pairs plus S=2 all 16 -> EQ/LT match A==B / A<B, latency matches k, one done per start.

Source files
------------

// File: rtl/cmp_ctrl_pkg.sv
// cmp_ctrl_pkg: shared state encoding and sizing helper for the serial comparator
package cmp_ctrl_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} cmp_state_t;

    function automatic int cnt_width(int s);
        return (s / 2 <= 1) ? 1 : $clog2(s / 2);
    endfunction

endpackage

// File: rtl/serial_compare_controller_slice.sv
// TwoBitCompareSlice: combinational two-bit compare stage with eq/lt cascade inputs
module TwoBitCompareSlice (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    input  logic       eq_i,
    input  logic       lt_i,
    output logic       eq_o,
    output logic       lt_o
);

    // a more-significant difference (eq_i=0) keeps its verdict; otherwise this pair decides
    always_comb begin
        eq_o = eq_i & (a_i == b_i);
        lt_o = lt_i | (eq_i & (a_i < b_i));
    end

endmodule

// File: rtl/serial_compare_controller.sv
// serial_compare_controller: time-shared two-bit slice magnitude comparator, MSB pair first
module serial_compare_controller #(
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [S-1:0] A,
    input  logic [S-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         EQ,
    output logic         LT
);

    import cmp_ctrl_pkg::*;

    localparam int CW = cnt_width(S);

    cmp_state_t    state_q, state_d;
    logic [S-1:0]  sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
    logic          eq_q, eq_d, lt_q, lt_d;
    logic          s_eq, s_lt;

    TwoBitCompareSlice u_slice (
        .a_i  (sa_q[S-1:S-2]),
        .b_i  (sb_q[S-1:S-2]),
        .eq_i (eq_acc_q),
        .lt_i (lt_acc_q),
        .eq_o (s_eq),
        .lt_o (s_lt)
    );

    // next state: load on start, shift one pair per RUN cycle, latch result on exit
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        eq_acc_d = eq_acc_q;
        lt_acc_d = lt_acc_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            ST_IDLE: if (start) begin
                sa_d     = A;
                sb_d     = B;
                eq_acc_d = 1'b1;
                lt_acc_d = 1'b0;
                cnt_d    = CW'(S / 2 - 1);
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                eq_acc_d = s_eq;
                lt_acc_d = s_lt;
                sa_d     = sa_q << 2;
                sb_d     = sb_q << 2;
                cnt_d    = cnt_q - CW'(1);
                if (!s_eq || cnt_q == '0) begin
                    eq_d    = s_eq;
                    lt_d    = s_lt;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers; reset discards any compare in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            eq_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            eq_acc_q <= eq_acc_d;
            lt_acc_q <= lt_acc_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign EQ   = eq_q;
    assign LT   = lt_q;

endmodule

// File: tb/tb_serial_compare_controller.sv
// tb_serial_compare_controller: table, directed and random checks at S=8, exhaustive at S=4 and S=2
module tb_serial_compare_controller;

    logic       clk = 0, rst = 1;
    logic       start8 = 0, start4 = 0, start2 = 0;
    logic [7:0] A8 = 0, B8 = 0;
    logic [3:0] A4 = 0, B4 = 0;
    logic [1:0] A2 = 0, B2 = 0;
    logic       busy8, done8, EQ8, LT8;
    logic       busy4, done4, EQ4, LT4;
    logic       busy2, done2, EQ2, LT2;

    int n_chk = 0, n_fail = 0;
    logic ex_eq [3];
    logic ex_lt [3];

    always #5 clk = ~clk;

    serial_compare_controller #(.S(8)) d8 (.clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
        .busy(busy8), .done(done8), .EQ(EQ8), .LT(LT8));
    serial_compare_controller #(.S(4)) d4 (.clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
        .busy(busy4), .done(done4), .EQ(EQ4), .LT(LT4));
    serial_compare_controller #(.S(2)) d2 (.clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2),
        .busy(busy2), .done(done2), .EQ(EQ2), .LT(LT2));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       eq;
        logic       lt;
        int         k;
    } vec_t;

    function automatic int wi(int w);
        return w == 8 ? 0 : w == 4 ? 1 : 2;
    endfunction

    function automatic logic g_busy(int w);
        return w == 8 ? busy8 : w == 4 ? busy4 : busy2;
    endfunction

    function automatic logic g_done(int w);
        return w == 8 ? done8 : w == 4 ? done4 : done2;
    endfunction

    function automatic logic g_eq(int w);
        return w == 8 ? EQ8 : w == 4 ? EQ4 : EQ2;
    endfunction

    function automatic logic g_lt(int w);
        return w == 8 ? LT8 : w == 4 ? LT4 : LT2;
    endfunction

    task automatic drive(int w, logic s, logic [7:0] a, logic [7:0] b);
        if (w == 8) begin start8 = s; A8 = a; B8 = b; end
        else if (w == 4) begin start4 = s; A4 = a[3:0]; B4 = b[3:0]; end
        else begin start2 = s; A2 = a[1:0]; B2 = b[1:0]; end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference: result from plain arithmetic, latency = index of first differing pair from the MSB
    task automatic model(int w, int a, int b, output logic eq, output logic lt, output int k);
        int m = (1 << w) - 1;
        eq = (a & m) == (b & m);
        lt = (a & m) < (b & m);
        k = w / 2;
        for (int i = 1; i <= w / 2; i++)
            if (((a >> (w - 2 * i)) & 3) != ((b >> (w - 2 * i)) & 3)) begin
                k = i;
                break;
            end
    endtask

    // one full compare: busy run length, done cycle and count, held results during RUN, final result
    task automatic run(int w, logic [7:0] a, logic [7:0] b, logic xe, logic xl, int xk, string nm);
        logic pe = ex_eq[wi(w)];
        logic pl = ex_lt[wi(w)];
        int nb = 0, nd = 0, dc = 0;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        for (int c = 1; c <= w / 2 + 3; c++) begin
            @(negedge clk);
            if (c == 1) drive(w, 1'b0, a, b);
            if (g_busy(w)) begin
                nb++;
                chk({nm, " hold_eq"}, int'(g_eq(w)), int'(pe));
                chk({nm, " hold_lt"}, int'(g_lt(w)), int'(pl));
            end
            if (g_done(w)) begin
                nd++;
                dc = c;
                chk({nm, " eq"}, int'(g_eq(w)), int'(xe));
                chk({nm, " lt"}, int'(g_lt(w)), int'(xl));
            end
        end
        chk({nm, " busy_cycles"}, nb, xk);
        chk({nm, " done_cycle"}, dc, xk + 1);
        chk({nm, " done_count"}, nd, 1);
        chk({nm, " eq_after"}, int'(g_eq(w)), int'(xe));
        chk({nm, " lt_after"}, int'(g_lt(w)), int'(xl));
        ex_eq[wi(w)] = xe;
        ex_lt[wi(w)] = xl;
    endtask

    initial begin
        vec_t tbl[7];
        logic me, ml;
        int mk, nd;
        logic [7:0] ra, rb;
        tbl[0] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 4};
        tbl[1] = '{8'h3F, 8'h40, 1'b0, 1'b1, 1};
        tbl[2] = '{8'hC4, 8'hC1, 1'b0, 1'b0, 3};
        tbl[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 4};
        tbl[4] = '{8'hFF, 8'hFE, 1'b0, 1'b0, 4};
        tbl[5] = '{8'h01, 8'h02, 1'b0, 1'b1, 4};
        tbl[6] = '{8'h80, 8'h40, 1'b0, 1'b0, 1};
        for (int i = 0; i < 3; i++) begin ex_eq[i] = 1'b0; ex_lt[i] = 1'b0; end

        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset busy8", int'(busy8), 0);
        chk("reset done8", int'(done8), 0);
        chk("reset eq8", int'(EQ8), 0);
        chk("reset lt8", int'(LT8), 0);
        chk("reset busy4", int'(busy4), 0);
        chk("reset busy2", int'(busy2), 0);

        for (int i = 0; i < 7; i++)
            run(8, tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].lt, tbl[i].k, $sformatf("tbl%0d", i));

        // start pulses during RUN and DONE with A=B=FF must be ignored
        @(negedge clk);
        drive(8, 1'b1, 8'h10, 8'h20);
        @(negedge clk);
        chk("ign c1 busy", int'(busy8), 1);
        drive(8, 1'b1, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("ign c2 busy", int'(busy8), 1);
        drive(8, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("ign c3 done", int'(done8), 1);
        chk("ign c3 eq", int'(EQ8), 0);
        chk("ign c3 lt", int'(LT8), 1);
        drive(8, 1'b1, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("ign c4 busy", int'(busy8), 0);
        chk("ign c4 done", int'(done8), 0);
        drive(8, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("ign c5 busy", int'(busy8), 0);
        chk("ign c5 eq", int'(EQ8), 0);
        chk("ign c5 lt", int'(LT8), 1);
        ex_eq[0] = 1'b0;
        ex_lt[0] = 1'b1;

        // reset in the middle of a compare: no done pulse, results cleared
        run(8, 8'h12, 8'h12, 1'b1, 1'b0, 4, "pre_rst");
        @(negedge clk);
        drive(8, 1'b1, 8'h77, 8'h77);
        @(negedge clk);
        drive(8, 1'b0, 8'h77, 8'h77);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst busy", int'(busy8), 0);
        chk("rst done", int'(done8), 0);
        chk("rst eq", int'(EQ8), 0);
        chk("rst lt", int'(LT8), 0);
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        chk("rst no_done", nd, 0);
        for (int i = 0; i < 3; i++) begin ex_eq[i] = 1'b0; ex_lt[i] = 1'b0; end
        run(8, 8'h77, 8'h77, 1'b1, 1'b0, 4, "post_rst");

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rb = 8'($urandom);
                1: rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = ra;
            endcase
            model(8, ra, rb, me, ml, mk);
            run(8, ra, rb, me, ml, mk, $sformatf("rnd %h/%h", ra, rb));
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                model(4, a, b, me, ml, mk);
                run(4, 8'(a), 8'(b), me, ml, mk, $sformatf("s4 %0d/%0d", a, b));
            end

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                model(2, a, b, me, ml, mk);
                run(2, 8'(a), 8'(b), me, ml, mk, $sformatf("s2 %0d/%0d", a, b));
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
